// File: rtl/axi_llc_ax_sequencer_pkg.sv
// rtl/axi_llc_ax_sequencer_pkg.sv - shared types, geometry and helpers for the LLC Ax sequencer
// Purpose: channel, descriptor and rule structs plus line/SPM geometry used by
//          the sequencer and its burst cutters.
// Ports:   none (package).
package axi_llc_ax_sequencer_pkg;

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned ID_W          = 4;
   localparam int unsigned NUM_WAYS      = 4;
   localparam int unsigned WAY_IDX_W     = $clog2(NUM_WAYS);
   localparam int unsigned LINE_BYTES    = 32;
   localparam int unsigned LINE_OFF_W    = $clog2(LINE_BYTES);
   localparam int unsigned LINE_IDX_W    = ADDR_W - LINE_OFF_W;
   localparam int unsigned SPM_WAY_BYTES = 32'h400;
   localparam int unsigned WAY_OFF_W     = $clog2(SPM_WAY_BYTES);

   // Whole scratchpad window: every way mapped back to back from the SPM base.
   localparam logic [ADDR_W-1:0] SPM_BYTES = ADDR_W'(NUM_WAYS * SPM_WAY_BYTES);

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [2:0]        prot;
      logic [3:0]        cache;
   } ax_chan_t;

   typedef ax_chan_t aw_chan_t;
   typedef ax_chan_t ar_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]     a_x_id;
      logic [ADDR_W-1:0]   a_x_addr;
      logic [7:0]          a_x_len;
      logic [2:0]          a_x_size;
      logic [1:0]          a_x_burst;
      logic [2:0]          a_x_prot;
      logic [3:0]          a_x_cache;
      logic [1:0]          x_resp;
      logic                x_last;
      logic                rw;
      logic                spm;
      logic [NUM_WAYS-1:0] way_ind;
   } desc_t;

   typedef struct packed {
      logic [31:0]       idx;
      logic [ADDR_W-1:0] start_addr;
      logic [ADDR_W-1:0] end_addr;
   } rule_t;

   // Beats from the (size-aligned) offset up to the end of its cache line.
   // Beats wider than a line always occupy exactly one line each.
   function automatic logic [8:0] beats_to_line_end(input logic [LINE_OFF_W-1:0] off,
                                                    input logic [2:0]            size);
      if (32'(size) >= LINE_OFF_W) begin
         return 9'd1;
      end
      return 9'((LINE_BYTES >> size) - (32'(off) >> size));
   endfunction

endpackage

// File: rtl/axi_llc_ax_sequencer_burst_cutter.sv
// rtl/axi_llc_ax_sequencer_burst_cutter.sv - splits the head of an Ax burst at the next line boundary
// Purpose: combinational; produces the descriptor for the first line segment of
//          i_chan and the channel that remains once that segment is consumed.
// Ports:   i_chan          held Ax channel (current remainder of the burst)
//          i_cached_start  cached region start (inclusive)
//          i_cached_end    cached region end (exclusive)
//          i_spm_start     scratchpad base address
//          o_desc          descriptor for the head segment
//          o_next_chan     remainder after the head segment (valid when !o_desc.x_last)
module axi_llc_ax_sequencer_burst_cutter
   import axi_llc_ax_sequencer_pkg::*;
#(
   parameter logic Write = 1'b0
)(
   input  ax_chan_t          i_chan,
   input  logic [ADDR_W-1:0] i_cached_start,
   input  logic [ADDR_W-1:0] i_cached_end,
   input  logic [ADDR_W-1:0] i_spm_start,
   output desc_t             o_desc,
   output ax_chan_t          o_next_chan
);

   logic [8:0]           w_total_beats;
   logic [8:0]           w_seg_beats;
   logic                 w_last;
   logic                 w_in_cached;
   logic                 w_in_spm;
   logic [ADDR_W-1:0]    w_spm_off;
   logic [WAY_IDX_W-1:0] w_way_idx;

   always_comb begin
      w_total_beats = {1'b0, i_chan.len} + 9'd1;
      w_seg_beats   = beats_to_line_end(i_chan.addr[LINE_OFF_W-1:0], i_chan.size);

      // Only INCR walks across lines; FIXED (and WRAP) go out as one descriptor.
      w_last = (i_chan.burst != BURST_INCR) || (w_total_beats <= w_seg_beats);

      w_in_cached = (i_chan.addr >= i_cached_start) && (i_chan.addr < i_cached_end);
      w_spm_off   = i_chan.addr - i_spm_start;
      w_in_spm    = (i_chan.addr >= i_spm_start) && (w_spm_off < SPM_BYTES);
      w_way_idx   = w_spm_off[WAY_OFF_W +: WAY_IDX_W];

      o_desc           = '0;
      o_desc.a_x_id    = i_chan.id;
      o_desc.a_x_addr  = i_chan.addr;
      o_desc.a_x_len   = w_last ? i_chan.len : 8'(w_seg_beats - 9'd1);
      o_desc.a_x_size  = i_chan.size;
      o_desc.a_x_burst = i_chan.burst;
      o_desc.a_x_prot  = i_chan.prot;
      o_desc.a_x_cache = i_chan.cache;
      o_desc.x_last    = w_last;
      o_desc.rw        = Write;
      o_desc.x_resp    = RESP_OKAY;

      // Cached region wins; SPM selects its way by address; anything else is a
      // decode error that still flows as a pinned SPM access so beat counts match.
      if (w_in_cached) begin
         o_desc.spm     = 1'b0;
         o_desc.way_ind = '0;
      end else if (w_in_spm) begin
         o_desc.spm     = 1'b1;
         o_desc.way_ind = NUM_WAYS'(1) << w_way_idx;
      end else begin
         o_desc.spm     = 1'b1;
         o_desc.way_ind = NUM_WAYS'(1);
         o_desc.x_resp  = RESP_SLVERR;
      end

      o_next_chan      = i_chan;
      o_next_chan.addr = {i_chan.addr[ADDR_W-1:LINE_OFF_W] + LINE_IDX_W'(1), LINE_OFF_W'(0)};
      o_next_chan.len  = 8'(w_total_beats - w_seg_beats - 9'd1);
   end

endmodule

// File: rtl/axi_llc_ax_sequencer.sv
// rtl/axi_llc_ax_sequencer.sv - arbitrates AW/AR and emits one LLC descriptor per line segment
// Purpose: accepts one Ax transaction at a time (round robin between AW and AR),
//          then streams its line-segment descriptors with valid/ready flow control.
// Ports:   clk_i, rst_i                   clock, async active-high reset
//          aw_chan_i/aw_valid_i/aw_ready_o write address channel
//          ar_chan_i/ar_valid_i/ar_ready_o read address channel
//          desc_o/desc_valid_o/desc_ready_i descriptor stream
//          cached_rule_i, spm_rule_i       address map (SPM uses start_addr only)
//          busy_o                          a transaction is held
module axi_llc_ax_sequencer
   import axi_llc_ax_sequencer_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  aw_chan_t aw_chan_i,
   input  logic     aw_valid_i,
   output logic     aw_ready_o,
   input  ar_chan_t ar_chan_i,
   input  logic     ar_valid_i,
   output logic     ar_ready_o,
   output desc_t    desc_o,
   output logic     desc_valid_o,
   input  logic     desc_ready_i,
   input  rule_t    cached_rule_i,
   input  rule_t    spm_rule_i,
   output logic     busy_o
);

   typedef enum logic [1:0] {IDLE, AW_BUSY, AR_BUSY} state_e;

   state_e   r_state;
   state_e   w_state_next;
   aw_chan_t r_aw_chan;
   aw_chan_t w_aw_chan_next;
   ar_chan_t r_ar_chan;
   ar_chan_t w_ar_chan_next;
   logic     r_last_grant_ar;
   logic     w_last_grant_ar_next;

   desc_t    w_aw_desc;
   desc_t    w_ar_desc;
   aw_chan_t w_aw_rest;
   ar_chan_t w_ar_rest;
   logic     w_grant_ar;

   logic     w_unused_rule_bits;
   assign w_unused_rule_bits = ^{cached_rule_i.idx, spm_rule_i.idx, spm_rule_i.end_addr};

   axi_llc_ax_sequencer_burst_cutter #(.Write(1'b1)) u_aw_cutter (
      .i_chan         (r_aw_chan),
      .i_cached_start (cached_rule_i.start_addr),
      .i_cached_end   (cached_rule_i.end_addr),
      .i_spm_start    (spm_rule_i.start_addr),
      .o_desc         (w_aw_desc),
      .o_next_chan    (w_aw_rest)
   );

   axi_llc_ax_sequencer_burst_cutter #(.Write(1'b0)) u_ar_cutter (
      .i_chan         (r_ar_chan),
      .i_cached_start (cached_rule_i.start_addr),
      .i_cached_end   (cached_rule_i.end_addr),
      .i_spm_start    (spm_rule_i.start_addr),
      .o_desc         (w_ar_desc),
      .o_next_chan    (w_ar_rest)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_aw_chan       <= '0;
         r_ar_chan       <= '0;
         r_last_grant_ar <= 1'b1;
      end else begin
         r_aw_chan       <= w_aw_chan_next;
         r_ar_chan       <= w_ar_chan_next;
         r_last_grant_ar <= w_last_grant_ar_next;
      end
   end

   always_comb begin
      w_state_next         = r_state;
      w_aw_chan_next       = r_aw_chan;
      w_ar_chan_next       = r_ar_chan;
      w_last_grant_ar_next = r_last_grant_ar;
      aw_ready_o           = 1'b0;
      ar_ready_o           = 1'b0;
      desc_valid_o         = 1'b0;
      desc_o               = w_aw_desc;

      // AR only when it is alone or AW had the previous turn; with no request
      // AW is offered ready so exactly one port is always ready in IDLE.
      w_grant_ar = ar_valid_i && (!aw_valid_i || !r_last_grant_ar);

      unique case (r_state)
         IDLE: begin
            aw_ready_o = !rst_i && !w_grant_ar;
            ar_ready_o = !rst_i && w_grant_ar;
            if (aw_valid_i && aw_ready_o) begin
               w_aw_chan_next       = aw_chan_i;
               w_last_grant_ar_next = 1'b0;
               w_state_next         = AW_BUSY;
            end else if (ar_valid_i && ar_ready_o) begin
               w_ar_chan_next       = ar_chan_i;
               w_last_grant_ar_next = 1'b1;
               w_state_next         = AR_BUSY;
            end
         end
         AW_BUSY: begin
            desc_valid_o = 1'b1;
            desc_o       = w_aw_desc;
            if (desc_ready_i) begin
               if (w_aw_desc.x_last) begin
                  w_state_next = IDLE;
               end else begin
                  w_aw_chan_next = w_aw_rest;
               end
            end
         end
         AR_BUSY: begin
            desc_valid_o = 1'b1;
            desc_o       = w_ar_desc;
            if (desc_ready_i) begin
               if (w_ar_desc.x_last) begin
                  w_state_next = IDLE;
               end else begin
                  w_ar_chan_next = w_ar_rest;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign busy_o = (r_state != IDLE);

`ifndef SYNTHESIS
   a_desc_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (desc_valid_o && !desc_ready_i) |=> (desc_valid_o && $stable(desc_o)));
   a_one_ready: assert property (@(posedge clk_i) !(aw_ready_o && ar_ready_o));
   a_ax_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      ((aw_valid_i && aw_ready_o) || (ar_valid_i && ar_ready_o)) |-> (r_state == IDLE));
`endif

endmodule

// File: tb/tb_axi_llc_ax_sequencer.sv
// tb/tb_axi_llc_ax_sequencer.sv - self-checking bench for axi_llc_ax_sequencer
module tb_axi_llc_ax_sequencer;
   import axi_llc_ax_sequencer_pkg::*;

   logic     clk_i = 1'b0;
   logic     rst_i = 1'b1;
   aw_chan_t aw_chan_i;
   logic     aw_valid_i = 1'b0;
   logic     aw_ready_o;
   ar_chan_t ar_chan_i;
   logic     ar_valid_i = 1'b0;
   logic     ar_ready_o;
   desc_t    desc_o;
   logic     desc_valid_o;
   logic     desc_ready_i = 1'b0;
   rule_t    cached_rule_i;
   rule_t    spm_rule_i;
   logic     busy_o;

   axi_llc_ax_sequencer dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .aw_chan_i     (aw_chan_i),
      .aw_valid_i    (aw_valid_i),
      .aw_ready_o    (aw_ready_o),
      .ar_chan_i     (ar_chan_i),
      .ar_valid_i    (ar_valid_i),
      .ar_ready_o    (ar_ready_o),
      .desc_o        (desc_o),
      .desc_valid_o  (desc_valid_o),
      .desc_ready_i  (desc_ready_i),
      .cached_rule_i (cached_rule_i),
      .spm_rule_i    (spm_rule_i),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   ax_chan_t aw_q[$];
   ax_chan_t ar_q[$];
   desc_t    exp_q[$];
   desc_t    got_q[$];
   bit       grant_log[$];   // 1 = AR granted
   bit       exp_busy   = 1'b0;
   bit       last_ar    = 1'b1;
   bit       stall_prev = 1'b0;
   desc_t    stall_desc;
   int       bp_mode    = 0;  // 0 always ready, 1 five low then one high, 2 random
   int       cyc        = 0;

   // Reference address map: cached [0, 0x10000), SPM 4 ways of 1 KiB from 0x100000.
   function automatic void ref_decode(input logic [31:0] a, output logic spm,
                                      output logic [3:0] way, output logic [1:0] resp);
      if (a < 32'h0001_0000) begin
         spm = 1'b0; way = 4'b0000; resp = 2'b00;
      end else if (a >= 32'h0010_0000 && a < 32'h0010_1000) begin
         spm = 1'b1; way = 4'(4'b0001 << ((a - 32'h0010_0000) / 32'h400)); resp = 2'b00;
      end else begin
         spm = 1'b1; way = 4'b0001; resp = 2'b10;
      end
   endfunction

   function automatic void emit(input ax_chan_t c, input logic [31:0] a, input int beats,
                                input bit last, input bit rw);
      desc_t d;
      d           = '0;
      d.a_x_id    = c.id;
      d.a_x_addr  = a;
      d.a_x_len   = 8'(beats - 1);
      d.a_x_size  = c.size;
      d.a_x_burst = c.burst;
      d.a_x_prot  = c.prot;
      d.a_x_cache = c.cache;
      d.x_last    = last;
      d.rw        = rw;
      ref_decode(a, d.spm, d.way_ind, d.x_resp);
      exp_q.push_back(d);
   endfunction

   // Walk every beat address of the burst and start a new descriptor whenever
   // a beat lands in a different 32-byte line than the segment's first beat.
   function automatic void build_exp(input ax_chan_t c, input bit rw);
      int unsigned bytes;
      int          nb;
      int          cnt;
      logic [31:0] a;
      logic [31:0] seg_a;
      nb    = int'(c.len) + 1;
      bytes = 1 << c.size;
      if (c.burst != 2'b01) begin
         emit(c, c.addr, nb, 1'b1, rw);
         return;
      end
      seg_a = c.addr;
      cnt   = 0;
      for (int k = 0; k < nb; k++) begin
         a = (k == 0) ? c.addr : ((c.addr / bytes) * bytes + k * bytes);
         if (k > 0 && (a / 32) != (seg_a / 32)) begin
            emit(c, seg_a, cnt, 1'b0, rw);
            seg_a = a;
            cnt   = 0;
         end
         cnt++;
      end
      emit(c, seg_a, cnt, 1'b1, rw);
   endfunction

   function automatic ax_chan_t mk_chan(input logic [3:0] id, input logic [31:0] addr,
                                        input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
      ax_chan_t c;
      c.id = id; c.addr = addr; c.len = len; c.size = size; c.burst = burst;
      c.prot = 3'($urandom()); c.cache = 4'($urandom());
      return c;
   endfunction

   function automatic ax_chan_t rand_chan();
      ax_chan_t    c;
      int          region;
      logic [31:0] a;
      region = $urandom_range(0, 2);
      if (region == 0)      a = 32'($urandom_range(0, 32'hFF00));
      else if (region == 1) a = 32'h0010_0000 + 32'($urandom_range(0, 32'hFF0));
      else                  a = 32'h0030_0000 + 32'($urandom_range(0, 32'hFFF));
      c = mk_chan(4'($urandom()), a, 8'($urandom_range(0, 31)), 3'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01);
      return c;
   endfunction

   task automatic drive();
      logic [63:0] junk;
      junk       = {$urandom(), $urandom()};
      aw_valid_i = (aw_q.size() > 0);
      aw_chan_i  = aw_valid_i ? aw_q[0] : junk[$bits(ax_chan_t)-1:0];
      junk       = {$urandom(), $urandom()};
      ar_valid_i = (ar_q.size() > 0);
      ar_chan_i  = ar_valid_i ? ar_q[0] : junk[$bits(ax_chan_t)-1:0];
      case (bp_mode)
         0:       desc_ready_i = 1'b1;
         1:       desc_ready_i = ((cyc % 6) == 5);
         default: desc_ready_i = ($urandom_range(0, 99) < 60);
      endcase
      cyc++;
   endtask

   task automatic step();
      logic hs_aw;
      logic hs_ar;
      logic hs_desc;
      logic exp_ar;
      hs_aw = 1'b0; hs_ar = 1'b0; hs_desc = 1'b0;
      @(negedge clk_i);
      if (rst_i) begin
         check("rst_desc_valid", desc_valid_o, 0);
         check("rst_aw_ready", aw_ready_o, 0);
         check("rst_ar_ready", ar_ready_o, 0);
         check("rst_busy", busy_o, 0);
      end else if (!exp_busy) begin
         exp_ar = ar_valid_i && (!aw_valid_i || !last_ar);
         check("idle_desc_valid", desc_valid_o, 0);
         check("idle_busy", busy_o, 0);
         check("arb_ar_ready", ar_ready_o, exp_ar);
         check("arb_aw_ready", aw_ready_o, !exp_ar);
         hs_aw = aw_valid_i && aw_ready_o;
         hs_ar = ar_valid_i && ar_ready_o;
      end else begin
         check("busy_aw_ready", aw_ready_o, 0);
         check("busy_ar_ready", ar_ready_o, 0);
         check("busy_desc_valid", desc_valid_o, 1);
         check("busy_flag", busy_o, 1);
         if (stall_prev) check("desc_stable", desc_o, stall_desc);
         hs_desc = desc_valid_o && desc_ready_i;
         if (hs_desc) begin
            check("desc", desc_o, exp_q.pop_front());
            got_q.push_back(desc_o);
         end
         stall_prev = desc_valid_o && !desc_ready_i;
         stall_desc = desc_o;
      end
      @(posedge clk_i);
      #1;
      if (hs_aw) begin
         build_exp(aw_q.pop_front(), 1'b1);
         exp_busy = 1'b1; last_ar = 1'b0; stall_prev = 1'b0;
         grant_log.push_back(1'b0);
      end else if (hs_ar) begin
         build_exp(ar_q.pop_front(), 1'b0);
         exp_busy = 1'b1; last_ar = 1'b1; stall_prev = 1'b0;
         grant_log.push_back(1'b1);
      end
      if (hs_desc && exp_q.size() == 0) exp_busy = 1'b0;
      drive();
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n;
      n = 0;
      while ((aw_q.size() > 0 || ar_q.size() > 0 || exp_busy) && n < budget) begin
         step();
         n++;
      end
      check({tag, "_done"}, aw_q.size() + ar_q.size() + exp_q.size(), 0);
      step();   // bubble cycle: must be back in IDLE
   endtask

   task automatic do_reset(input int cycles);
      rst_i = 1'b1;
      aw_q.delete(); ar_q.delete(); exp_q.delete();
      exp_busy = 1'b0; last_ar = 1'b1; stall_prev = 1'b0;
      drive();
      for (int i = 0; i < cycles; i++) step();
      rst_i = 1'b0;
   endtask

   logic [31:0] s1_addr[3] = '{32'h10, 32'h20, 32'h40};
   logic [7:0]  s1_len[3]  = '{8'd1, 8'd3, 8'd1};
   logic        s1_last[3] = '{1'b0, 1'b0, 1'b1};

   task automatic check_s1(input string tag);
      check({tag, "_count"}, got_q.size(), 3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         check({tag, "_addr"}, got_q[i].a_x_addr, s1_addr[i]);
         check({tag, "_len"}, got_q[i].a_x_len, s1_len[i]);
         check({tag, "_last"}, got_q[i].x_last, s1_last[i]);
         check({tag, "_rw"}, got_q[i].rw, 0);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      cached_rule_i = '{idx: 32'd0, start_addr: 32'h0, end_addr: 32'h0001_0000};
      spm_rule_i    = '{idx: 32'd1, start_addr: 32'h0010_0000, end_addr: 32'h0};

      // Reset state, then AW and AR both valid from reset: strict alternation, AW first.
      do_reset(3);
      for (int i = 0; i < 3; i++) begin
         aw_q.push_back(mk_chan(4'(i), 32'h100 + 32'(i * 32), 8'd0, 3'd3, 2'b01));
         ar_q.push_back(mk_chan(4'(i), 32'h200 + 32'(i * 32), 8'd1, 3'd3, 2'b01));
      end
      drive();
      grant_log.delete();
      run_until_done("s3", 200);
      check("s3_grants", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         check("s3_order", grant_log[i], (i % 2));

      // Scenario 1: AR 0x10 len 7 size 3 INCR, always ready.
      bp_mode = 0;
      got_q.delete();
      ar_q.push_back(mk_chan(4'd5, 32'h10, 8'd7, 3'd3, 2'b01));
      run_until_done("s1", 100);
      check_s1("s1");

      // Scenario 4: same with 5-cycle backpressure per descriptor.
      bp_mode = 1;
      got_q.delete();
      ar_q.push_back(mk_chan(4'd6, 32'h10, 8'd7, 3'd3, 2'b01));
      run_until_done("s4", 200);
      check_s1("s4");

      // Scenario 2: AW FIXED len 15 -> one descriptor.
      bp_mode = 0;
      got_q.delete();
      aw_q.push_back(mk_chan(4'd7, 32'h08, 8'd15, 3'd3, 2'b00));
      run_until_done("s2", 100);
      check("s2_count", got_q.size(), 1);
      if (got_q.size() > 0) begin
         check("s2_len", got_q[0].a_x_len, 15);
         check("s2_last", got_q[0].x_last, 1);
         check("s2_rw", got_q[0].rw, 1);
      end

      // Scenario 5: AR to unmapped address -> decode error descriptor.
      got_q.delete();
      ar_q.push_back(mk_chan(4'd8, 32'h0020_0000, 8'd3, 3'd3, 2'b01));
      run_until_done("s5", 100);
      check("s5_count", got_q.size(), 1);
      if (got_q.size() > 0) begin
         check("s5_spm", got_q[0].spm, 1);
         check("s5_way", got_q[0].way_ind, 4'b0001);
         check("s5_resp", got_q[0].x_resp, 2'b10);
      end

      // Scenario 6: reset after the first descriptor of scenario 1.
      got_q.delete();
      ar_q.push_back(mk_chan(4'd9, 32'h10, 8'd7, 3'd3, 2'b01));
      drive();
      n = 0;
      while (got_q.size() < 1 && n < 50) begin
         step();
         n++;
      end
      check("s6_first_desc", got_q.size(), 1);
      do_reset(2);
      step();
      got_q.delete();
      ar_q.push_back(mk_chan(4'd10, 32'h30, 8'd3, 3'd3, 2'b01));
      run_until_done("s6_after", 100);
      check("s6_after_count", got_q.size(), 2);

      // Randomised traffic on both ports with random backpressure.
      bp_mode = 2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) aw_q.push_back(rand_chan());
         else                           ar_q.push_back(rand_chan());
      end
      run_until_done("rand", 20000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
